// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and segment patterns for the stopwatch display.
package seg_pkg;

    localparam int unsigned NUM_DIGITS   = 4;
    localparam int unsigned BCD_WIDTH    = 16;
    localparam int unsigned BIN_WIDTH    = 14;
    localparam int unsigned SHIFT_CYCLES = 14;

    // Active-low patterns, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Digit 0-9 to active-low segment pattern, dp off; non-decimal codes blank
    function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
        logic [7:0] pat;
        case (digit)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to four BCD nibbles in 14 shifts.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_WIDTH-1:0] bcd
);

    conv_state_e          state;
    conv_state_e          next_state;
    logic [3:0]           shift_cnt;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [BCD_WIDTH-1:0] acc_adj;

    // Add-3 correction on every nibble >= 5 ahead of the shift
    always_comb begin
        acc_adj = bcd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic for the IDLE -> SHIFT -> COMMIT sequence
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_SHIFT;
            ST_SHIFT:  if (shift_cnt == 4'(SHIFT_CYCLES - 1)) next_state = ST_COMMIT;
            ST_COMMIT: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // State register, status flags and shift datapath; bcd holds the accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            shift_cnt <= 4'd0;
            bin_sr    <= '0;
            bcd       <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state != ST_IDLE);
            done  <= (next_state == ST_COMMIT);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr    <= bin;
                        bcd       <= '0;
                        shift_cnt <= 4'd0;
                    end
                end
                ST_SHIFT: begin
                    bcd       <= {acc_adj[BCD_WIDTH-2:0], bin_sr[BIN_WIDTH-1]};
                    bin_sr    <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
                    shift_cnt <= shift_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg_disp_ctrl.sv
// Four-digit multiplexed 7-segment driver for an SS.cc stopwatch.
// Optional macro SEG_BLANK_LZ_EN blanks a leading zero on digit 3.
module seg_disp_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DP_POS  = 2,
    parameter int unsigned SAT_VAL = 9999
) (
    input  logic                 clk100Mhz,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [BIN_WIDTH-1:0] segData,
    input  logic                 idle,
    output logic [7:0]           seg,
    output logic [3:0]           an,
    output logic                 busy
);

    logic [BIN_WIDTH-1:0] last_val;
    logic [BIN_WIDTH-1:0] sat_bin_c;
    logic                 start_c;
    logic                 conv_done;
    logic [BCD_WIDTH-1:0] conv_bcd;
    logic [3:0]           disp [NUM_DIGITS];
    logic [1:0]           scan;
    logic [7:0]           seg_next_c;

    // Clamp to the displayable range and start only on a changed value while idle
    always_comb begin
        sat_bin_c = (32'(segData) > SAT_VAL) ? BIN_WIDTH'(SAT_VAL) : segData;
        start_c   = (segData != last_val) && !busy;
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk100Mhz),
        .rst   (rst),
        .start (start_c),
        .bin   (sat_bin_c),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Segment pattern for the currently scanned digit
    always_comb begin
        seg_next_c = seg_pattern(disp[scan]);
        if (idle) begin
            seg_next_c = SEG_DASH;
        end else begin
`ifdef SEG_BLANK_LZ_EN
            if ((scan == 2'd3) && (disp[3] == 4'd0) && (DP_POS < 3)) begin
                seg_next_c = SEG_BLANK;
            end
`endif
            if (scan == 2'(DP_POS)) begin
                seg_next_c[7] = 1'b0;
            end
        end
    end

    // Last-value tracking, display registers, scan counter and registered outputs
    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            last_val <= '0;
            scan     <= 2'd0;
            an       <= 4'b1110;
            seg      <= 8'hC0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                disp[i] <= 4'd0;
            end
        end else begin
            if (start_c) begin
                last_val <= segData;
            end
            if (conv_done) begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    disp[i] <= conv_bcd[4*i +: 4];
                end
            end
            if (tick) begin
                scan <= scan + 2'd1;
            end
            an  <= ~(4'b0001 << scan);
            seg <= seg_next_c;
        end
    end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench for seg_disp_ctrl: directed scenarios plus random traffic vs a value-level model.
module tb_seg_disp_ctrl;

    logic        clk100Mhz;
    logic        rst;
    logic        tick;
    logic [13:0] segData;
    logic        idle;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept as plain integers
    int         m_scan;
    int         m_shown;
    int         m_last;
    int         m_pend;
    int         m_left;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_busy;

    logic [7:0] digit_pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int         pow10 [4] = '{1, 10, 100, 1000};

    seg_disp_ctrl dut (
        .clk100Mhz (clk100Mhz),
        .rst       (rst),
        .tick      (tick),
        .segData   (segData),
        .idle      (idle),
        .seg       (seg),
        .an        (an),
        .busy      (busy)
    );

    initial begin
        clk100Mhz = 1'b0;
        forever #5 clk100Mhz = ~clk100Mhz;
    end

    function automatic logic [7:0] model_seg(input int pos, input int val, input logic idl);
        int         d;
        logic [7:0] s;
        d = (val / pow10[pos]) % 10;
        s = digit_pat[d];
        if (idl) return 8'hBF;
`ifdef SEG_BLANK_LZ_EN
        if (pos == 3 && d == 0) return 8'hFF;
`endif
        if (pos == 2) s[7] = 1'b0;
        return s;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: inputs already driven, model advanced on the edge, outputs checked on the falling edge
    task automatic step(input logic t);
        tick = t;
        @(posedge clk100Mhz);
        if (rst) begin
            m_scan = 0; m_shown = 0; m_last = 0; m_pend = 0; m_left = 0;
            exp_an = 4'b1110; exp_seg = 8'hC0; exp_busy = 1'b0;
        end else begin
            exp_an  = ~(4'b0001 << m_scan);
            exp_seg = model_seg(m_scan, m_shown, idle);
            if (t) m_scan = (m_scan + 1) % 4;
            if (m_left == 0) begin
                if (int'(segData) != m_last) begin
                    m_last = int'(segData);
                    m_pend = (m_last > 9999) ? 9999 : m_last;
                    m_left = 15;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_shown = m_pend;
            end
            exp_busy = (m_left != 0);
        end
        @(negedge clk100Mhz);
        check("an",   8'(an),   8'(exp_an));
        check("seg",  seg,      exp_seg);
        check("busy", 8'(busy), 8'(exp_busy));
    endtask

    initial begin
        int busy_cycles;
        int rises;
        logic prev_busy;
        logic found;

        rst = 1'b1; tick = 1'b0; segData = '0; idle = 1'b0;

        // Reset for three cycles with a zero input
        for (int i = 0; i < 3; i++) step(1'b0);
        check("rst_an",   8'(an), 8'h0E);
        check("rst_seg",  seg,    8'hC0);
        check("rst_busy", 8'(busy), 8'h00);
        rst = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (busy) busy_cycles++;
        end
        check("no_conv_after_rst", 8'(busy_cycles), 8'd0);

        // 1234: busy for 15 clocks, then digit 2 shows "2" with dp
        segData = 14'd1234;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (busy) busy_cycles++;
        end
        check("busy_len_1234", 8'(busy_cycles), 8'd15);
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        check("an_digit2", 8'(an), 8'h0B);
        check("seg_digit2_1234", seg, 8'h24);

        // Saturation of 16383 to 9999
        segData = 14'h3FFF;
        for (int i = 0; i < 20; i++) step(1'b0);
        step(1'b1); step(1'b0);
        check("an_digit3_sat", 8'(an), 8'h07);
        check("seg_digit3_sat", seg, 8'h90);
        step(1'b1); step(1'b0);
        check("seg_digit0_sat", seg, 8'h90);

        // Change during conversion: both values committed, two busy windows
        segData = 14'd100;
        rises = 0; prev_busy = busy;
        for (int i = 0; i < 45; i++) begin
            if (i == 5) segData = 14'd200;
            step(1'b0);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        check("two_conversions", 8'(rises), 8'd2);

        // Idle dash pattern while scanning continues
        idle = 1'b1;
        step(1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            step(1'b0);
            check("idle_dash", seg, 8'hBF);
        end
        idle = 1'b0;

        // Leading zero on digit 3 with value 42
        segData = 14'd42;
        for (int i = 0; i < 20; i++) step(1'b0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step(1'b1);
            step(1'b0);
            if (an === 4'b0111) found = 1'b1;
        end
        check("lz_digit3_reached", 8'(found), 8'd1);
`ifdef SEG_BLANK_LZ_EN
        check("lz_digit3_seg", seg, 8'hFF);
`else
        check("lz_digit3_seg", seg, 8'hC0);
`endif
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        check("lz_digit2_seg", seg, 8'h40);

        // Random traffic: ticks, value changes, idle toggles and occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 3) == 0) segData = 14'($urandom_range(0, 16383));
                else segData = 14'($urandom_range(0, 9999));
            end
            if ($urandom_range(0, 49) == 0) idle = ~idle;
            step(1'($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
